// File: rtl/sensor_line_capture_pkg.sv
// Shared definitions for the sensor line capture path and the readout logic behind it.
// Holds the line state encoding, the default geometry and a saturating counter helper.
package sensor_pkg;

  localparam int DEF_PIXELS = 1024;
  localparam int DEF_ADC_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } line_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sensor_line_capture_if.sv
// Reader-side port of the line capture block: buffer read port plus line ready/ack handshake.
// The master modport is the capture side, the slave modport is the downstream reader.
interface sensor_line_capture_if
  import sensor_pkg::*;
#(
  parameter int PIXELS = DEF_PIXELS,
  parameter int ADC_W  = DEF_ADC_W
);

  localparam int PW = $clog2(PIXELS);
  localparam int CW = $clog2(PIXELS + 1);

  logic [PW-1:0]    RD_ADDR;
  logic [ADC_W-1:0] RD_DATA;
  logic             LINE_READY;
  logic             LINE_SHORT;
  logic             LINE_ACK;
  logic [CW-1:0]    PIX_COUNT;

  modport master (
    input  RD_ADDR, LINE_ACK,
    output RD_DATA, LINE_READY, LINE_SHORT, PIX_COUNT
  );

  modport slave (
    output RD_ADDR, LINE_ACK,
    input  RD_DATA, LINE_READY, LINE_SHORT, PIX_COUNT
  );

endinterface

// File: rtl/sensor_line_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous sensor input, followed by a registered
// one-cycle rising-edge pulse (input rise to pulse is three clock edges).
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      o_rise <= r_sync & ~r_prev;
    end
  end

endmodule

// File: rtl/sensor_line_capture.sv
// Captures one sensor line per ST cycle into an on-chip buffer and hands it to the reader
// through a ready/ack handshake; counts lines lost when a new ST arrives before the ack.
module sensor_line_capture
  import sensor_pkg::*;
#(
  parameter int PIXELS = DEF_PIXELS,
  parameter int ADC_W  = DEF_ADC_W,
  parameter int SKIP   = 0
) (
  input  logic             FPGA_CLK,
  input  logic             FPGA_RST,
  input  logic             ST,
  input  logic             TRG,
  input  logic [ADC_W-1:0] ADC_DATA,
  input  logic             EOC_EDGE,
  output logic             BUSY,
  output logic [7:0]       OVERRUN_CNT,
  sensor_line_capture_if.master rd_if
);

  localparam int CW = $clog2(PIXELS + 1);
  localparam int PW = $clog2(PIXELS);
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic [1:0]    S_IDLE = IDLE;
  localparam logic [1:0]    S_ACQ  = ACQ;
  localparam logic [1:0]    S_DONE = DONE;
  localparam logic [CW-1:0] FULL   = CW'(PIXELS);
  localparam logic [SW-1:0] SKIP_N = SW'(SKIP);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_pix;
  logic [SW-1:0]    r_skip;
  logic             r_short;
  logic [7:0]       r_ovr;
  logic             r_st;
  logic             r_st_fall;
  logic [ADC_W-1:0] r_mem [PIXELS];
  logic [ADC_W-1:0] r_rd_data;

  logic             w_trg_rise;
  logic             w_store;
  logic             w_skip_done;
  logic [CW-1:0]    w_pix_next;

  sync_edge u_trg_sync (
    .i_clk   (FPGA_CLK),
    .i_rst   (FPGA_RST),
    .i_async (TRG),
    .o_rise  (w_trg_rise)
  );

  // ST is already in this clock domain; the fall pulse is registered so ACQ starts two edges after ST drops.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_st      <= 1'b0;
      r_st_fall <= 1'b0;
    end else begin
      r_st      <= ST;
      r_st_fall <= r_st & ~ST;
    end
  end

  assign w_skip_done = (r_skip == SKIP_N);
  assign w_store     = (r_state == S_ACQ) && !r_st_fall && w_trg_rise && w_skip_done && (r_pix < FULL);
  assign w_pix_next  = r_pix + CW'(w_store);

  always_ff @(posedge FPGA_CLK) begin
    if (w_store) begin
      r_mem[r_pix[PW-1:0]] <= ADC_DATA;
    end
    r_rd_data <= r_mem[rd_if.RD_ADDR];
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_state <= S_IDLE;
      r_pix   <= '0;
      r_skip  <= '0;
      r_short <= 1'b0;
      r_ovr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_st_fall) begin
            r_state <= S_ACQ;
            r_pix   <= '0;
            r_skip  <= '0;
            r_short <= 1'b0;
          end
        end
        S_ACQ: begin
          if (r_st_fall) begin
            r_pix   <= '0;
            r_skip  <= '0;
            r_short <= 1'b0;
            r_ovr   <= sat_inc8(r_ovr);
          end else begin
            r_pix <= w_pix_next;
            if (w_trg_rise && !w_skip_done) begin
              r_skip <= r_skip + SW'(1);
            end
            // A pixel arriving with EOC_EDGE is counted before the line is judged short.
            if (w_pix_next == FULL) begin
              r_state <= S_DONE;
              r_short <= 1'b0;
            end else if (EOC_EDGE) begin
              r_state <= S_DONE;
              r_short <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (rd_if.LINE_ACK) begin
            if (r_st_fall) begin
              r_state <= S_ACQ;
              r_pix   <= '0;
              r_skip  <= '0;
              r_short <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_st_fall) begin
            r_ovr <= sat_inc8(r_ovr);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY             = (r_state == S_ACQ);
  assign OVERRUN_CNT      = r_ovr;
  assign rd_if.LINE_READY = (r_state == S_DONE);
  assign rd_if.LINE_SHORT = r_short;
  assign rd_if.PIX_COUNT  = r_pix;
  assign rd_if.RD_DATA    = r_rd_data;

endmodule

// File: tb/tb_sensor_line_capture.sv
// Bench for sensor_line_capture: two instances (SKIP=0 and SKIP=2) share one stimulus stream
// and are compared every cycle against a line-level model, plus hand-computed spot checks.
module tb_sensor_line_capture;
  import sensor_pkg::*;

  localparam int PIXELS = 8;
  localparam int ADC_W  = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             st;
  logic             trg;
  logic [ADC_W-1:0] adc;
  logic             eoc;
  logic             lineAck;
  logic [2:0]       rdAddr;
  bit               randAddr = 0;

  logic             dutBusy  [2];
  logic [7:0]       dutOvr   [2];
  logic             dutReady [2];
  logic             dutShort [2];
  logic [3:0]       dutPix   [2];
  logic [ADC_W-1:0] dutRd    [2];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sensor_line_capture_if #(.PIXELS(PIXELS), .ADC_W(ADC_W)) if0 ();
  sensor_line_capture_if #(.PIXELS(PIXELS), .ADC_W(ADC_W)) if1 ();

  assign if0.LINE_ACK = lineAck;
  assign if0.RD_ADDR  = rdAddr;
  assign if1.LINE_ACK = lineAck;
  assign if1.RD_ADDR  = rdAddr;

  sensor_line_capture #(.PIXELS(PIXELS), .ADC_W(ADC_W), .SKIP(0)) dut0 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .ST(st), .TRG(trg), .ADC_DATA(adc), .EOC_EDGE(eoc),
    .BUSY(dutBusy[0]), .OVERRUN_CNT(dutOvr[0]), .rd_if(if0)
  );

  sensor_line_capture #(.PIXELS(PIXELS), .ADC_W(ADC_W), .SKIP(2)) dut1 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .ST(st), .TRG(trg), .ADC_DATA(adc), .EOC_EDGE(eoc),
    .BUSY(dutBusy[1]), .OVERRUN_CNT(dutOvr[1]), .rd_if(if1)
  );

  assign dutReady[0] = if0.LINE_READY;
  assign dutShort[0] = if0.LINE_SHORT;
  assign dutPix[0]   = if0.PIX_COUNT;
  assign dutRd[0]    = if0.RD_DATA;
  assign dutReady[1] = if1.LINE_READY;
  assign dutShort[1] = if1.LINE_SHORT;
  assign dutPix[1]   = if1.PIX_COUNT;
  assign dutRd[1]    = if1.RD_DATA;

  // Line-level model: a line is idle, being captured, or held for the reader.
  bit               modelLive = 0;
  bit               hTrg [5];
  bit               hSt  [3];
  bit               mAcq [2];
  bit               mReady [2];
  bit               mShort [2];
  bit               mRdValid [2];
  int               mPix [2];
  int               mSkip [2];
  int               mOvr [2];
  logic [ADC_W-1:0] mMem [2][PIXELS];
  logic [ADC_W-1:0] mRd [2];

  function automatic int skipOf(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit trgRise;
    bit stFall;
    bit okPrev;
    for (int k = 4; k > 0; k--) hTrg[k] = hTrg[k-1];
    hTrg[0] = trg;
    hSt[2] = hSt[1];
    hSt[1] = hSt[0];
    hSt[0] = st;
    if (rst) begin
      modelLive = 1;
      for (int k = 0; k < 5; k++) hTrg[k] = 0;
      for (int k = 0; k < 3; k++) hSt[k] = 0;
      for (int u = 0; u < 2; u++) begin
        mAcq[u] = 0; mReady[u] = 0; mShort[u] = 0; mRdValid[u] = 0;
        mPix[u] = 0; mSkip[u] = 0; mOvr[u] = 0;
      end
    end else begin
      // A TRG rise shows up three edges later; an ST fall is acted on two edges after it is seen.
      trgRise = hTrg[3] && !hTrg[4];
      stFall  = hSt[2] && !hSt[1];
      for (int u = 0; u < 2; u++) begin
        mRd[u] = mMem[u][rdAddr];
        okPrev = mReady[u] && (int'(rdAddr) < mPix[u]);
        if (mAcq[u]) begin
          if (stFall) begin
            mPix[u] = 0; mSkip[u] = 0; mShort[u] = 0;
            if (mOvr[u] < 255) mOvr[u]++;
          end else begin
            if (trgRise && mPix[u] < PIXELS) begin
              if (mSkip[u] < skipOf(u)) mSkip[u]++;
              else begin
                mMem[u][mPix[u]] = adc;
                mPix[u]++;
              end
            end
            if (mPix[u] == PIXELS) begin
              mAcq[u] = 0; mReady[u] = 1; mShort[u] = 0;
            end else if (eoc) begin
              mAcq[u] = 0; mReady[u] = 1; mShort[u] = 1;
            end
          end
        end else if (mReady[u]) begin
          if (lineAck) begin
            mReady[u] = 0;
            if (stFall) begin
              mAcq[u] = 1; mPix[u] = 0; mSkip[u] = 0; mShort[u] = 0;
            end
          end else if (stFall && mOvr[u] < 255) begin
            mOvr[u]++;
          end
        end else if (stFall) begin
          mAcq[u] = 1; mPix[u] = 0; mSkip[u] = 0; mShort[u] = 0;
        end
        mRdValid[u] = okPrev && mReady[u];
      end
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      for (int u = 0; u < 2; u++) begin
        checkOutput($sformatf("ready%0d", u), 32'(dutReady[u]), 32'(mReady[u]));
        checkOutput($sformatf("busy%0d", u), 32'(dutBusy[u]), 32'(mAcq[u]));
        checkOutput($sformatf("short%0d", u), 32'(dutShort[u]), 32'(mShort[u]));
        checkOutput($sformatf("pixCount%0d", u), 32'(dutPix[u]), 32'(mPix[u]));
        checkOutput($sformatf("overrun%0d", u), 32'(dutOvr[u]), 32'(mOvr[u]));
        if (mRdValid[u]) checkOutput($sformatf("rdData%0d", u), 32'(dutRd[u]), 32'(mRd[u]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randAddr) rdAddr = 3'($urandom_range(0, PIXELS - 1));
  endtask

  task automatic stPulse();
    st = 1'b1; tick();
    st = 1'b0; tick();
    tick();
  endtask

  task automatic trgPulse(input logic [ADC_W-1:0] data, input bit withEoc);
    adc = data;
    for (int c = 0; c < 6; c++) begin
      trg = (c < 3);
      eoc = withEoc && (c == 3);
      tick();
    end
    eoc = 1'b0;
  endtask

  task automatic eocPulse();
    eoc = 1'b1; tick();
    eoc = 1'b0; tick();
  endtask

  task automatic ackPulse();
    lineAck = 1'b1; tick();
    lineAck = 1'b0; tick();
  endtask

  // LINE_ACK lands on the same edge that consumes the ST fall.
  task automatic ackWithSt();
    st = 1'b1; tick();
    st = 1'b0; tick();
    lineAck = 1'b1; tick();
    lineAck = 1'b0;
  endtask

  task automatic resetPulse();
    rst = 1'b1; tick();
    rst = 1'b0;
  endtask

  task automatic readCheck(input int u, input int addr, input logic [ADC_W-1:0] exp);
    rdAddr = 3'(addr);
    tick();
    checkOutput($sformatf("lineData%0d[%0d]", u, addr), 32'(dutRd[u]), 32'(exp));
  endtask

  task automatic applyStimulus(input int kind);
    if (kind < 2) stPulse();
    else if (kind < 11) trgPulse(ADC_W'($urandom), ($urandom_range(0, 7) == 0));
    else if (kind == 11) eocPulse();
    else if (kind < 14) ackPulse();
    else if (kind == 14) ackWithSt();
    else if (kind == 15 && $urandom_range(0, 3) == 0) resetPulse();
    else repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; trg = 1'b0; adc = '0; eoc = 1'b0; lineAck = 1'b0; rdAddr = '0;
    #1;
    tick(); tick();
    checkOutput("rstReady", 32'(dutReady[0]), 32'd0);
    checkOutput("rstBusy", 32'(dutBusy[0]), 32'd0);
    checkOutput("rstPix", 32'(dutPix[0]), 32'd0);
    checkOutput("rstShort", 32'(dutShort[0]), 32'd0);
    checkOutput("rstOverrun", 32'(dutOvr[0]), 32'd0);
    rst = 1'b0;
    tick();

    stPulse();
    for (int i = 0; i < 8; i++) trgPulse(12'h100 + 12'(i), 0);
    tick(); tick();
    checkOutput("fullReady", 32'(dutReady[0]), 32'd1);
    checkOutput("fullPix", 32'(dutPix[0]), 32'd8);
    checkOutput("fullShort", 32'(dutShort[0]), 32'd0);
    checkOutput("skipPixSoFar", 32'(dutPix[1]), 32'd6);
    checkOutput("skipStillBusy", 32'(dutBusy[1]), 32'd1);
    for (int i = 0; i < 8; i++) readCheck(0, i, 12'h100 + 12'(i));
    trgPulse(12'h108, 0);
    trgPulse(12'h109, 0);
    tick();
    checkOutput("skipReady", 32'(dutReady[1]), 32'd1);
    checkOutput("fullPixHeld", 32'(dutPix[0]), 32'd8);
    for (int i = 0; i < 8; i++) readCheck(1, i, 12'h102 + 12'(i));
    readCheck(0, 0, 12'h100);

    ackPulse();
    stPulse();
    for (int i = 0; i < 5; i++) trgPulse(12'h180 + 12'(i), 0);
    eocPulse();
    checkOutput("eocPix", 32'(dutPix[0]), 32'd5);
    checkOutput("eocShort", 32'(dutShort[0]), 32'd1);
    checkOutput("eocReady", 32'(dutReady[0]), 32'd1);
    checkOutput("eocSkipPix", 32'(dutPix[1]), 32'd3);

    ackPulse();
    stPulse();
    for (int i = 0; i < 4; i++) trgPulse(12'h200 + 12'(i), 0);
    trgPulse(12'h204, 1);
    checkOutput("coincPix", 32'(dutPix[0]), 32'd5);
    checkOutput("coincShort", 32'(dutShort[0]), 32'd1);
    checkOutput("coincReady", 32'(dutReady[0]), 32'd1);

    stPulse();
    checkOutput("overrunOne", 32'(dutOvr[0]), 32'd1);
    checkOutput("overrunPixKept", 32'(dutPix[0]), 32'd5);
    readCheck(0, 4, 12'h204);

    ackWithSt();
    checkOutput("ackStBusy", 32'(dutBusy[0]), 32'd1);
    checkOutput("ackStOverrun", 32'(dutOvr[0]), 32'd1);

    for (int i = 0; i < 3; i++) trgPulse(12'h2A0 + 12'(i), 0);
    resetPulse();
    checkOutput("midRstBusy", 32'(dutBusy[0]), 32'd0);
    checkOutput("midRstPix", 32'(dutPix[0]), 32'd0);
    checkOutput("midRstOverrun", 32'(dutOvr[0]), 32'd0);
    tick();
    stPulse();
    for (int i = 0; i < 8; i++) trgPulse(12'h300 + 12'(i), 0);
    tick();
    checkOutput("cleanPix", 32'(dutPix[0]), 32'd8);
    checkOutput("cleanReady", 32'(dutReady[0]), 32'd1);
    readCheck(0, 7, 12'h307);

    for (int i = 0; i < 300; i++) begin
      st = 1'b1; tick();
      st = 1'b0; tick();
    end
    tick(); tick();
    checkOutput("overrunSat0", 32'(dutOvr[0]), 32'd255);
    checkOutput("overrunSat1", 32'(dutOvr[1]), 32'd255);

    randAddr = 1;
    resetPulse();
    tick();
    for (int i = 0; i < 400; i++) applyStimulus(int'($urandom_range(0, 19)));
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
